// File: rtl/mdu_seq_pkg.sv
// Shared EX-stage decode constants and the multiply/divide sequencer state encoding.
package mdu_seq_pkg;

    localparam logic [5:0] F_add   = 6'd32;
    localparam logic [5:0] F_sub   = 6'd34;
    localparam logic [5:0] F_and   = 6'd36;
    localparam logic [5:0] F_or    = 6'd37;
    localparam logic [5:0] F_slt   = 6'd42;
    localparam logic [5:0] F_srl   = 6'd2;

    localparam logic [5:0] F_mfhi  = 6'd16;
    localparam logic [5:0] F_mflo  = 6'd18;
    localparam logic [5:0] F_multu = 6'd25;
    localparam logic [5:0] F_divu  = 6'd27;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10
    } state_t;

    // Any funct that touches HI/LO or the unit and must wait for an op in flight
    function automatic logic is_mdu_op(input logic [5:0] f);
        return (f == F_mfhi) || (f == F_mflo) || (f == F_multu) || (f == F_divu);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One multiply (shift-add) or divide (restoring shift-subtract) iteration on the working register.
module mdu_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opnd,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH:0]   trial;

    // Multiply: acc = {partial product, remaining multiplier}; divide: acc = {remainder, dividend/quotient}
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        rem_sh   = {acc[2*WIDTH-2:WIDTH], acc[WIDTH-1]};
        trial    = {acc[2*WIDTH-1], rem_sh} - {1'b0, opnd};
        acc_next = '0;
        if (is_div) begin
            if (!trial[WIDTH]) begin
                acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh, acc[WIDTH-2:0], 1'b0};
            end
        end else if (acc[0]) begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Iterative unsigned MULTU/DIVU sequencer holding architectural HI/LO, with EX-stage stall and MFHI/MFLO read.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   opnd;
    logic               start;
    logic               start_div;
    logic               step_div;
    logic               last;

    assign busy      = (state != IDLE);
    assign start_div = (funct == F_divu);
    assign start     = ex_valid & ~busy & ((funct == F_multu) | start_div);
    assign stall     = ex_valid & busy & is_mdu_op(funct);
    assign rd_data   = (funct == F_mfhi) ? hi : lo;
    assign step_div  = (state == DIV);
    assign last      = (cnt == CNT_W'(WIDTH - 1));

    mdu_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div   (step_div),
        .acc      (acc),
        .opnd     (opnd),
        .acc_next (acc_next)
    );

    // Sequencer: capture operands on start, iterate, commit HI/LO on the final step
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            opnd  <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        acc   <= {WIDTH'(0), (start_div ? src_a : src_b)};
                        opnd  <= start_div ? src_b : src_a;
                        state <= start_div ? DIV : MUL;
                    end
                end
                MUL, DIV: begin
                    if (step_div && (opnd == '0)) begin
                        // Divide by zero: dividend to HI, all-ones quotient, no iterations
                        hi    <= acc[WIDTH-1:0];
                        lo    <= '1;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + CNT_W'(1);
                        if (last) begin
                            hi    <= acc_next[2*WIDTH-1:WIDTH];
                            lo    <= acc_next[WIDTH-1:0];
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
